pwm_packet_transmitter: RTL and testbench

PWM_PACKET_TRANSMITTER -- requirements
Module: pwm_packet_transmitter

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_tx_timer.sv | 25 ++
 rtl/pwm_packet_transmitter.sv | 150 +++++++++++++++
 tb/tb_pwm_packet_transmitter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM packet link: transmitter state encoding and
// the receiver's acceptance windows, which the transmitter parameters must fit.
package pwm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SOP,
        SYM_HI,
        SYM_LO,
        EOP
    } tx_state_t;

    // Receiver acceptance windows (durations in clk cycles, ratios in percent)
    localparam int RX_SOP_MIN      = 80;
    localparam int RX_EOP_MIN      = 80;
    localparam int RX_LEN_MAX      = 255;
    localparam int RX_SYM_MIN      = 10;
    localparam int RX_SYM_MAX      = 40;
    localparam int RX_ZERO_PCT_MIN = 11;
    localparam int RX_ZERO_PCT_MAX = 40;
    localparam int RX_ONE_PCT_MIN  = 53;
    localparam int RX_ONE_PCT_MAX  = 75;

endpackage

// File: rtl/pwm_tx_timer.sv
// 8-bit loadable down-counter; holds at zero and flags it.
module pwm_tx_timer (
    input  logic       clk,
    input  logic       rstz,
    input  logic       i_load,
    input  logic [7:0] i_value,
    output logic [7:0] o_count,
    output logic       o_zero
);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (!rstz)
            r_count <= 8'd0;
        else if (i_load)
            r_count <= i_value;
        else if (r_count != 8'd0)
            r_count <= r_count - 8'd1;
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == 8'd0);

endmodule

// File: rtl/pwm_packet_transmitter.sv
// Sends one 4-bit nibble as a differential PWM packet: SOP (00), four symbols
// (10 then 01, duty encodes the bit, MSB first), EOP (11), then a done pulse.
module pwm_packet_transmitter
    import pwm_pkg::*;
#(
    parameter int SOP_LEN = 100,
    parameter int EOP_LEN = 100,
    parameter int SYM_LEN = 20,
    parameter int ONE_HI  = 13,
    parameter int ZERO_HI = 5
) (
    input  logic       clk,
    input  logic       rstz,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic       TX_P,
    output logic       TX_N,
    output logic       busy,
    output logic       done
);

    localparam int ZERO_PCT = (ZERO_HI * 100) / SYM_LEN;
    localparam int ONE_PCT  = (ONE_HI * 100) / SYM_LEN;

    // Timings outside the receiver windows must never reach silicon
    if (!(ZERO_HI >= 1 && ZERO_HI < ONE_HI && ONE_HI < SYM_LEN &&
          SYM_LEN >= RX_SYM_MIN && SYM_LEN <= RX_SYM_MAX &&
          SOP_LEN >= RX_SOP_MIN && SOP_LEN <= RX_LEN_MAX &&
          EOP_LEN >= RX_EOP_MIN && EOP_LEN <= RX_LEN_MAX &&
          ZERO_PCT >= RX_ZERO_PCT_MIN && ZERO_PCT <= RX_ZERO_PCT_MAX &&
          ONE_PCT >= RX_ONE_PCT_MIN && ONE_PCT <= RX_ONE_PCT_MAX)) begin : g_bad_params
        $error("pwm_packet_transmitter: illegal PWM timing parameters");
    end

    function automatic logic [7:0] hi_len(input logic b);
        return b ? 8'(ONE_HI) : 8'(ZERO_HI);
    endfunction

    tx_state_t  r_state;
    logic [3:0] r_shift;
    logic [1:0] r_sym;
    logic       r_tx_p, r_tx_n, r_in_ready, r_busy, r_done;

    logic       w_load;
    logic [7:0] w_load_val;
    logic [7:0] w_count;
    logic       w_zero;
    logic [7:0] w_h_cur, w_h_next;

    assign w_h_cur  = hi_len(r_shift[3]);
    assign w_h_next = hi_len(r_shift[2]);

    // Timer is reloaded with (length-1) on every state entry
    always_comb begin
        w_load     = 1'b0;
        w_load_val = 8'd0;
        case (r_state)
            IDLE:   if (r_in_ready && in_valid) begin
                        w_load     = 1'b1;
                        w_load_val = 8'(SOP_LEN - 1);
                    end
            SOP:    if (w_zero) begin
                        w_load     = 1'b1;
                        w_load_val = w_h_cur - 8'd1;
                    end
            SYM_HI: if (w_zero) begin
                        w_load     = 1'b1;
                        w_load_val = 8'(SYM_LEN) - w_h_cur - 8'd1;
                    end
            SYM_LO: if (w_zero) begin
                        w_load     = 1'b1;
                        w_load_val = (r_sym == 2'd3) ? 8'(EOP_LEN - 1) : w_h_next - 8'd1;
                    end
            default: ;
        endcase
    end

    pwm_tx_timer u_timer (
        .clk     (clk),
        .rstz    (rstz),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_count (w_count),
        .o_zero  (w_zero)
    );

    always_ff @(posedge clk) begin
        if (!rstz) begin
            r_state    <= IDLE;
            r_shift    <= 4'd0;
            r_sym      <= 2'd0;
            r_tx_p     <= 1'b1;
            r_tx_n     <= 1'b1;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (r_in_ready && in_valid) begin
                    r_shift    <= in_data;
                    r_sym      <= 2'd0;
                    r_state    <= SOP;
                    {r_tx_p, r_tx_n} <= 2'b00;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b1;
                end
                SOP: if (w_zero) begin
                    r_state <= SYM_HI;
                    {r_tx_p, r_tx_n} <= 2'b10;
                end
                SYM_HI: if (w_zero) begin
                    r_state <= SYM_LO;
                    {r_tx_p, r_tx_n} <= 2'b01;
                end
                SYM_LO: if (w_zero) begin
                    r_shift <= {r_shift[2:0], 1'b0};
                    if (r_sym == 2'd3) begin
                        r_state <= EOP;
                        {r_tx_p, r_tx_n} <= 2'b11;
                    end else begin
                        r_sym   <= r_sym + 2'd1;
                        r_state <= SYM_HI;
                        {r_tx_p, r_tx_n} <= 2'b10;
                    end
                end
                EOP: if (w_zero) begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                end
                default: begin
                    r_state    <= IDLE;
                    {r_tx_p, r_tx_n} <= 2'b11;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign TX_P     = r_tx_p;
    assign TX_N     = r_tx_n;
    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_pwm_packet_transmitter.sv
// Bench for pwm_packet_transmitter: per-cycle comparison of {TX_P,TX_N,in_ready,busy,done}
// against a waveform list built from the packet format.
module tb_pwm_packet_transmitter;

    localparam int SOP_LEN = 100;
    localparam int EOP_LEN = 100;
    localparam int SYM_LEN = 20;
    localparam int ONE_HI  = 13;
    localparam int ZERO_HI = 5;

    logic       clk = 1'b0;
    logic       rstz;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready, TX_P, TX_N, busy, done;

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] exp_q[$];

    pwm_packet_transmitter #(
        .SOP_LEN(SOP_LEN), .EOP_LEN(EOP_LEN), .SYM_LEN(SYM_LEN),
        .ONE_HI(ONE_HI), .ZERO_HI(ZERO_HI)
    ) dut (
        .clk      (clk),
        .rstz     (rstz),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .TX_P     (TX_P),
        .TX_N     (TX_N),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] V_IDLE = 5'b11100;

    function automatic logic [4:0] obs();
        return {TX_P, TX_N, in_ready, busy, done};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected line/handshake per cycle after acceptance, ending with the done cycle
    task automatic build(input logic [3:0] d);
        int h;
        exp_q.delete();
        repeat (SOP_LEN) exp_q.push_back(5'b00010);
        for (int b = 3; b >= 0; b--) begin
            h = d[b] ? ONE_HI : ZERO_HI;
            repeat (h) exp_q.push_back(5'b10010);
            repeat (SYM_LEN - h) exp_q.push_back(5'b01010);
        end
        repeat (EOP_LEN) exp_q.push_back(5'b11010);
        exp_q.push_back(5'b11101);
    endtask

    task automatic start(input logic [3:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
    endtask

    // hold: keep in_valid high (with next data) into the next packet; poke: busy-time request cycle
    task automatic chk_pkt(input logic [3:0] d, input logic hold, input logic [3:0] nd, input int poke);
        build(d);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            if (k == 0) begin
                in_valid = hold;
                in_data  = nd;
            end
            if (poke >= 0 && k == poke) begin
                in_valid = 1'b1;
                in_data  = 4'h9;
            end
            if (poke >= 0 && k == poke + 1)
                in_valid = 1'b0;
            chk($sformatf("pkt%h_c%0d", d, k + 1), {3'b0, obs()}, {3'b0, exp_q[k]});
        end
    endtask

    task automatic chk_idle(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk($sformatf("%s_%0d", tag, k), {3'b0, obs()}, {3'b0, V_IDLE});
        end
    endtask

    initial begin
        logic [3:0] d;
        rstz     = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'hF;
        repeat (3) @(negedge clk);
        chk("reset_state", {3'b0, obs()}, {3'b0, V_IDLE});
        in_valid = 1'b0;
        rstz     = 1'b1;
        chk_idle(2, "post_reset");

        // Reference packet: 4'hA
        start(4'hA);
        chk_pkt(4'hA, 1'b0, 4'h0, -1);
        chk_idle(3, "after_A");

        // Boundary data patterns and busy-time request ignored
        start(4'h0);
        chk_pkt(4'h0, 1'b0, 4'h0, 50);
        start(4'hF);
        chk_pkt(4'hF, 1'b0, 4'h0, 130);
        start(4'h5);
        chk_pkt(4'h5, 1'b0, 4'h0, -1);
        chk_idle(1, "after_5");

        // Back-to-back with in_valid held: 3 then C
        start(4'h3);
        chk_pkt(4'h3, 1'b1, 4'hC, -1);
        chk_pkt(4'hC, 1'b0, 4'h0, -1);
        chk_idle(2, "after_b2b");

        // Randomized packets with random idle gaps
        for (int i = 0; i < 6; i++) begin
            d = 4'($urandom_range(0, 15));
            chk_idle($urandom_range(0, 4), $sformatf("gap%0d", i));
            start(d);
            chk_pkt(d, 1'b0, 4'($urandom_range(0, 15)), $urandom_range(0, 1) ? int'($urandom_range(1, 270)) : -1);
        end

        // Reset mid-packet at cycle 150
        start(4'h7);
        build(4'h7);
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (k == 0) in_valid = 1'b0;
            chk($sformatf("abort_c%0d", k + 1), {3'b0, obs()}, {3'b0, exp_q[k]});
        end
        rstz = 1'b0;
        @(negedge clk);
        chk("abort_line", {3'b0, obs()}, {3'b0, V_IDLE});
        in_valid = 1'b1;
        in_data  = 4'h6;
        @(negedge clk);
        chk("abort_hold", {3'b0, obs()}, {3'b0, V_IDLE});
        rstz = 1'b1;
        @(posedge clk);
        chk_pkt(4'h6, 1'b0, 4'h0, -1);
        chk_idle(2, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
